// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle control unit.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALTED
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_LO = 4'h1;
    localparam logic [3:0] OP_ALU_HI = 4'hA;
    localparam logic [3:0] OP_MOVI   = 4'hB;
    localparam logic [3:0] OP_ST     = 4'hC;
    localparam logic [3:0] OP_BZ     = 4'hD;
    localparam logic [3:0] OP_BP     = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [3:0] ALU_MOVI  = 4'b1011;

    typedef struct packed {
        logic is_nop;
        logic is_alu;
        logic is_movi;
        logic is_st;
        logic is_bz;
        logic is_bp;
        logic is_halt;
    } op_class_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decode: register fields, ALU controls,
// sign-extended immediate and a one-hot operation class.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [REG_AW-1:0]  rs_addr,
    output logic [REG_AW-1:0]  rt_addr,
    output logic [REG_AW-1:0]  rd_addr,
    output logic [DATA_W-1:0]  imm_data,
    output logic [3:0]         alu_sel,
    output logic               imm_sel,
    output op_class_t          op_class
);
    localparam int IMM_W = INSTR_W - 4 - REG_AW;

    logic [3:0]       opcode;
    logic [IMM_W-1:0] imm_raw;

    assign opcode   = ir[INSTR_W-1 -: 4];
    assign rd_addr  = ir[INSTR_W-5 -: REG_AW];
    assign rs_addr  = ir[INSTR_W-5-REG_AW -: REG_AW];
    assign rt_addr  = ir[INSTR_W-5-2*REG_AW -: REG_AW];
    // Immediate deliberately overlaps rs/rt; it fills everything below rd.
    assign imm_raw  = ir[IMM_W-1:0];
    assign imm_data = DATA_W'($signed(imm_raw));

    always_comb begin
        op_class = '0;
        alu_sel  = 4'h0;
        imm_sel  = 1'b0;
        case (opcode)
            OP_NOP:  op_class.is_nop = 1'b1;
            OP_MOVI: begin
                op_class.is_movi = 1'b1;
                alu_sel          = ALU_MOVI;
                imm_sel          = 1'b1;
            end
            OP_ST:   op_class.is_st   = 1'b1;
            OP_BZ:   op_class.is_bz   = 1'b1;
            OP_BP:   op_class.is_bp   = 1'b1;
            OP_HALT: op_class.is_halt = 1'b1;
            default: begin
                op_class.is_alu = 1'b1;
                alu_sel         = opcode;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with external
// instruction fetch handshake, conditional relative branches and HALT.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter int              PC_W     = 5,
    parameter int              REG_AW   = 3,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               instr_req,
    output logic [PC_W-1:0]    instr_addr,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               zero_flag,
    input  logic               pos_flag,
    output logic               rf_write,
    output logic [REG_AW-1:0]  rs_addr,
    output logic [REG_AW-1:0]  rt_addr,
    output logic [REG_AW-1:0]  rd_addr,
    output logic [DATA_W-1:0]  imm_data,
    output logic [3:0]         alu_sel,
    output logic               imm_sel,
    output logic               mem_write,
    input  logic               mem_ready,
    output logic [PC_W-1:0]    PC,
    output logic               halted
);
    state_t             state;
    logic [INSTR_W-1:0] ir;
    op_class_t          op_class;
    logic               branch_taken;

    ctrl_decoder #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW)
    ) u_dec (
        .ir       (ir),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .imm_data (imm_data),
        .alu_sel  (alu_sel),
        .imm_sel  (imm_sel),
        .op_class (op_class)
    );

    assign instr_addr   = PC;
    assign branch_taken = (op_class.is_bz && zero_flag) || (op_class.is_bp && pos_flag);

    // Strobes are registered from the next state, so instr_req first rises
    // one cycle after reset release and a fetch is accepted only once it is up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            PC        <= RESET_PC;
            ir        <= '0;
            instr_req <= 1'b0;
            rf_write  <= 1'b0;
            mem_write <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_req && instr_valid) begin
                        ir        <= instr_data;
                        PC        <= PC + 1'b1;
                        instr_req <= 1'b0;
                        state     <= DECODE;
                    end else begin
                        instr_req <= 1'b1;
                    end
                end
                DECODE: begin
                    mem_write <= op_class.is_st;
                    state     <= EXECUTE;
                end
                EXECUTE: begin
                    if (op_class.is_alu || op_class.is_movi) begin
                        rf_write <= 1'b1;
                        state    <= WRITEBACK;
                    end else if (op_class.is_st) begin
                        if (mem_ready) begin
                            mem_write <= 1'b0;
                            instr_req <= 1'b1;
                            state     <= FETCH;
                        end
                    end else if (op_class.is_halt) begin
                        halted <= 1'b1;
                        state  <= HALTED;
                    end else if (op_class.is_nop) begin
                        instr_req <= 1'b1;
                        state     <= FETCH;
                    end else begin
                        // Branch offset is relative to the already-incremented PC.
                        if (branch_taken)
                            PC <= PC + imm_data[PC_W-1:0];
                        instr_req <= 1'b1;
                        state     <= FETCH;
                    end
                end
                WRITEBACK: begin
                    rf_write  <= 1'b0;
                    instr_req <= 1'b1;
                    state     <= FETCH;
                end
                HALTED: ;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against an instruction-level model.
module tb_multicycle_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [4:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        zero_flag;
    logic        pos_flag;
    logic        rf_write;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [2:0]  rd_addr;
    logic [15:0] imm_data;
    logic [3:0]  alu_sel;
    logic        imm_sel;
    logic        mem_write;
    logic        mem_ready;
    logic [4:0]  PC;
    logic        halted;

    int n_chk  = 0;
    int n_pass = 0;
    int model_pc = 0;

    multicycle_control_unit dut (
        .clock       (clock),
        .reset       (reset),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .zero_flag   (zero_flag),
        .pos_flag    (pos_flag),
        .rf_write    (rf_write),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rd_addr     (rd_addr),
        .imm_data    (imm_data),
        .alu_sel     (alu_sel),
        .imm_sel     (imm_sel),
        .mem_write   (mem_write),
        .mem_ready   (mem_ready),
        .PC          (PC),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Inputs outside FETCH carry junk; the controller must ignore them.
    task automatic noise();
        instr_valid = 1'($urandom);
        instr_data  = 16'($urandom);
        mem_ready   = 1'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},  instr_req, 0);
        chk({tag, "_rf"},   rf_write, 0);
        chk({tag, "_mw"},   mem_write, 0);
        chk({tag, "_halt"}, halted, 0);
        chk({tag, "_regs"}, {rs_addr, rt_addr, rd_addr}, 0);
        chk({tag, "_imm"},  imm_data, 0);
        chk({tag, "_alu"},  {alu_sel, imm_sel}, 0);
        chk({tag, "_pc"},   PC, 0);
        chk({tag, "_addr"}, instr_addr, 0);
    endtask

    task automatic chk_dec(input string tag, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic [3:0] alu, input logic isel,
                           input logic [15:0] imm);
        chk({tag, "_rd"},   rd_addr, rd);
        chk({tag, "_rs"},   rs_addr, rs);
        chk({tag, "_rt"},   rt_addr, rt);
        chk({tag, "_alu"},  alu_sel, alu);
        chk({tag, "_isel"}, imm_sel, isel);
        chk({tag, "_imm"},  imm_data, imm);
    endtask

    // Assert reset at a negedge, check outputs go to zero at once, release
    // at the next negedge, and expect instr_req one cycle after release.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk_zero({tag, "_async"});
        @(negedge clock);
        chk_zero({tag, "_held"});
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr_data  = 16'hB1FF;
        model_pc    = 0;
        @(negedge clock);
        chk({tag, "_req_up"}, instr_req, 1);
        chk({tag, "_rf0"}, rf_write, 0);
        chk({tag, "_pc0"}, PC, 0);
    endtask

    // Run one instruction from a FETCH cycle (instr_req already high) to the
    // next FETCH cycle, checking every cycle against the instruction model.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [8:0] imm9,
                             input int stall, input logic flag, input int wait_n);
        logic [15:0] word;
        logic [15:0] exp_imm;
        logic [3:0]  exp_alu;
        logic [2:0]  exp_rs, exp_rt;
        int          simm;
        bit          is_wb;
        word    = {op, rd, imm9};
        simm    = imm9[8] ? int'(imm9) - 512 : int'(imm9);
        exp_imm = 16'(simm);
        exp_alu = (op >= 4'h1 && op <= 4'hB) ? op : 4'h0;
        exp_rs  = 3'((int'(imm9) >> 6) & 7);
        exp_rt  = 3'((int'(imm9) >> 3) & 7);
        is_wb   = (op >= 4'h1 && op <= 4'hB);

        for (int k = 0; k <= stall; k++) begin
            chk("fetch_req", instr_req, 1);
            chk("fetch_addr", instr_addr, 32'(model_pc));
            chk("fetch_pc", PC, 32'(model_pc));
            chk("fetch_strobes", {rf_write, mem_write, halted}, 0);
            instr_valid = (k == stall);
            instr_data  = (k == stall) ? word : 16'($urandom);
            @(negedge clock);
        end
        model_pc = (model_pc + 1) % 32;

        noise();
        zero_flag = !flag;
        pos_flag  = !flag;
        chk("dec_pc", PC, 32'(model_pc));
        chk("dec_strobes", {instr_req, rf_write, mem_write, halted}, 0);
        chk_dec("dec", rd, exp_rs, exp_rt, exp_alu, op == 4'hB, exp_imm);
        @(negedge clock);

        noise();
        zero_flag = (op == 4'hD) ? flag : 1'($urandom);
        pos_flag  = (op == 4'hE) ? flag : 1'($urandom);
        chk_dec("ex", rd, exp_rs, exp_rt, exp_alu, op == 4'hB, exp_imm);
        chk("ex_req", instr_req, 0);
        chk("ex_rf", rf_write, 0);
        chk("ex_halt", halted, 0);
        chk("ex_mw", mem_write, op == 4'hC);

        if (op == 4'hC) begin
            for (int k = 0; k <= wait_n; k++) begin
                chk("st_mw", mem_write, 1);
                chk("st_rf", rf_write, 0);
                chk("st_req", instr_req, 0);
                mem_ready = (k == wait_n);
                @(negedge clock);
                noise();
            end
        end else if (is_wb) begin
            @(negedge clock);
            noise();
            chk("wb_rf", rf_write, 1);
            chk("wb_rd", rd_addr, rd);
            chk("wb_req_mw", {instr_req, mem_write}, 0);
            @(negedge clock);
        end else if (op == 4'hF) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                noise();
                chk("halt_flag", halted, 1);
                chk("halt_strobes", {instr_req, rf_write, mem_write}, 0);
                chk("halt_pc", PC, 32'(model_pc));
            end
            return;
        end else begin
            if ((op == 4'hD || op == 4'hE) && flag)
                model_pc = ((model_pc + simm) % 32 + 32) % 32;
            @(negedge clock);
        end

        chk("next_req", instr_req, 1);
        chk("next_strobes", {rf_write, mem_write, halted}, 0);
        chk("next_pc", PC, 32'(model_pc));
    endtask

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        zero_flag   = 1'b0;
        pos_flag    = 1'b0;
        mem_ready   = 1'b0;
        @(negedge clock);
        do_reset("rst");

        // Branch wrap cases, then NOPs to reach PC=4 for MOVI.
        run_instr(4'hD, 3'd0, 9'h1FE, 0, 1'b0, 0);
        run_instr(4'hD, 3'd0, 9'h1FE, 0, 1'b1, 0);
        run_instr(4'hD, 3'd0, 9'h1FE, 0, 1'b1, 0);
        chk("bz_wrap_31", PC, 31);
        run_instr(4'hD, 3'd0, 9'h1FE, 0, 1'b1, 0);
        run_instr(4'hE, 3'd0, 9'h003, 0, 1'b1, 0);
        chk("bp_wrap_2", PC, 2);
        run_instr(4'h0, 3'd0, 9'h000, 0, 1'b0, 0);
        run_instr(4'h0, 3'd0, 9'h000, 0, 1'b0, 0);
        run_instr(4'hB, 3'd6, 9'h008, 0, 1'b0, 0);
        chk("movi_pc5", PC, 5);
        run_instr(4'hB, 3'd1, 9'h1FD, 3, 1'b0, 0);
        run_instr(4'h3, 3'd2, 9'b001_100_000, 0, 1'b0, 0);
        run_instr(4'hC, 3'd0, 9'h000, 0, 1'b0, 2);
        run_instr(4'hC, 3'd5, 9'h0AB, 1, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            run_instr(4'($urandom_range(0, 14)), 3'($urandom), 9'($urandom),
                      $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3));

        // Reset in the EXECUTE cycle of an ALU op must suppress the write.
        chk("pre_mid_req", instr_req, 1);
        instr_valid = 1'b1;
        instr_data  = {4'h5, 3'd7, 9'h0F0};
        @(negedge clock);
        noise();
        @(negedge clock);
        chk("mid_ex_alu", alu_sel, 5);
        do_reset("mid");
        run_instr(4'h2, 3'd3, 9'h055, 0, 1'b0, 0);

        for (int i = 0; i < 10; i++)
            run_instr(4'($urandom_range(0, 14)), 3'($urandom), 9'($urandom),
                      $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3));

        run_instr(4'hF, 3'd0, 9'h000, 0, 1'b0, 0);
        do_reset("post_halt");
        run_instr(4'h0, 3'd0, 9'h000, 1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor of the CPU core's multi-cycle control unit. It fetches instructions from an external program memory over a req/valid handshake instead of an internal ROM. It sequences FETCH/DECODE/EXECUTE/WRITEBACK and drives register-file, ALU and data-memory controls. New behaviour over the previous control unit:
- flag-conditional relative branches
- store back-pressure via mem_ready
- HALT
- width/depth parameters

Parameters:
DATA_W, 16, datapath width; imm_data is sign-extended to this width.
INSTR_W, 16, instruction width; must satisfy INSTR_W >= 4 + 3*REG_AW + 1.
PC_W, 5, program counter width; PC wraps modulo 2^PC_W.
REG_AW, 3, register-file address width (2^REG_AW registers).
RESET_PC, 0, PC value loaded on reset.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
instr_req  out  1  fetch request to program memory.
instr_addr  out  PC_W  fetch address; equals PC while instr_req=1.
instr_valid  in  1  instr_data is valid this cycle.
instr_data  in  INSTR_W  fetched instruction.
zero_flag  in  1  ALU zero flag.
pos_flag  in  1  ALU positive flag.
rf_write  out  1  register-file write enable.
rs_addr  out  REG_AW  source register A.
rt_addr  out  REG_AW  source register B.
rd_addr  out  REG_AW  destination register.
imm_data  out  DATA_W  sign-extended immediate.
alu_sel  out  4  ALU operation select.
imm_sel  out  1  ALU B operand = imm_data.
mem_write  out  1  data-memory write strobe.
mem_ready  in  1  data memory accepts the write this cycle.
PC  out  PC_W  program counter (address of next instruction).
halted  out  1  core stopped by HALT.

Behaviour:
Instruction fields (MSB first):
- opcode[4]
- rd[REG_AW]
- rs[REG_AW]
- rt[REG_AW]
- imm = low INSTR_W-4-REG_AW bits, overlapping rs/rt; 9 bits at defaults, sign-extended to DATA_W.

Opcodes:
- 0x0 NOP.
- 0x1..0xA ALU register ops: alu_sel=opcode, imm_sel=0.
- 0xB MOVI: alu_sel=4'b1011, imm_sel=1.
- 0xC ST: mem_write.
- 0xD BZ: branch if zero_flag.
- 0xE BP: branch if pos_flag.
- 0xF HALT.

Reset (async assert, sync release):
- state=FETCH, PC=RESET_PC, IR=0.
- All outputs 0 except instr_addr=RESET_PC. instr_req rises the first cycle after release.

FSM states:
- FETCH: instr_req=1. Stay while instr_valid=0. On instr_valid: latch IR, PC<=PC+1 (wraps), go to DECODE. instr_valid outside FETCH is ignored.
- DECODE: rs/rt/rd_addr, alu_sel, imm_sel, imm_data are driven from IR. They stay stable through EXECUTE and WRITEBACK and hold their values until the next IR latch. Always goes to EXECUTE.
- EXECUTE, by opcode:
  - ALU/MOVI: go to WRITEBACK.
  - NOP: go to FETCH.
  - BZ/BP: flags are sampled this cycle only. If taken, PC<=PC+sext(imm) mod 2^PC_W, relative to the already-incremented PC. Go to FETCH.
  - ST: mem_write=1, held until the cycle mem_ready=1, then go to FETCH. No timeout.
  - HALT: go to HALTED.
- WRITEBACK: rf_write=1 for exactly one cycle, then go to FETCH.
- HALTED: halted=1. All strobes are 0. Only reset exits.

Timing and invariants:
- Minimum latency with instr_valid in the FETCH cycle: ALU/MOVI = 4 cycles, NOP/branch = 3, ST = 3 + mem_ready wait.
- rf_write, mem_write and instr_req are mutually exclusive.
- Reset mid-instruction discards the instruction. No partial write completes after reset deassertion.

Decomposition:
- ctrl_pkg holds:
  - state_t enum {FETCH, DECODE, EXECUTE, WRITEBACK, HALTED}
  - opcode localparams OP_NOP .. OP_HALT
  - ALU_MOVI=4'b1011
- Sub-module ctrl_decoder: combinational decode of IR into register addresses, alu_sel, imm_sel, sign-extended imm_data, and an op-class flag set. The top level holds the FSM, PC and IR.

Test Plan:
1. MOVI R6,#8 at PC=4, instr_valid same cycle as req -> after DECODE: rd_addr=6, alu_sel=4'b1011, imm_sel=1, imm_data=16'h0008. PC=5. rf_write=1 exactly in the 4th cycle, 0 otherwise.
2. MOVI R1,#-3 -> imm_data=16'hFFFD. ALU op 0x3 with rd=2, rs=1, rt=4 -> alu_sel=4'h3, imm_sel=0, rs_addr=1, rt_addr=4.
3. Fetch stall: instr_valid held low 3 cycles -> instr_req=1 and instr_addr=PC stable for 4 cycles. PC does not advance until valid.
4. BZ imm=-2 at PC=0 (PC becomes 1):
   - zero_flag=1 -> PC=31 (wrap).
   - zero_flag=0 -> PC=1.
   - BP imm=+3 with pos_flag=1 at PC=30 -> PC=2.
5. ST with mem_ready low 2 cycles -> mem_write high 3 cycles. rf_write stays 0. Next FETCH starts the cycle after mem_ready=1.
6. HALT -> halted=1 and instr_req=0 indefinitely. Async reset asserted mid-EXECUTE of an ALU op -> all outputs 0 immediately, no rf_write pulse, PC=RESET_PC after release.
